// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter device: register offsets, CTRL
// bit positions, mode encodings and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Only the exact auto-reload encoding reloads; every other MODE is one-shot.
  function automatic logic is_reload(input logic [3:0] ctrl);
    return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter_prescaler.sv
// Clock divider for the timer: o_tick strobes once every PRESCALE clocks,
// restarting from zero whenever i_clear is high.
module tc_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] r_cnt;
  logic        w_tick;

  assign w_tick = (r_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and IRQ.
// Define TC_PRESCALE_EN to gate each count step by a PRESCALE-clock divider.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ,
  output logic [1:0]  o_dbg_state
);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("timer_counter: PRESCALE out of range 1..65535");
  end

  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;
  tc_state_e   r_state;

  logic w_ctrl_we;
  logic w_preset_we;
  logic w_en;
  logic w_reload;
  logic w_tick;

  assign w_ctrl_we   = We && (Addr == TC_CTRL);
  assign w_preset_we = We && (Addr == TC_PRESET);
  assign w_en        = r_ctrl[CTRL_EN];
  assign w_reload    = is_reload(r_ctrl);

`ifdef TC_PRESCALE_EN
  logic w_ps_clear;
  assign w_ps_clear = (r_state == ST_LOAD) || !w_en;

  tc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_ps_clear),
    .o_tick  (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
      r_state    <= ST_IDLE;
    end else begin
      if (w_preset_we) r_preset <= DIn;

      case (r_state)
        ST_IDLE: if (w_en) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count <= '0;
              r_state <= ST_INT;
            end
          end
        end
        ST_INT: begin
          if (!w_reload) r_ctrl[CTRL_EN] <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Placed after the FSM so a CPU CTRL write overrides the one-shot EN clear.
      if (w_ctrl_we) r_ctrl <= DIn[3:0];

      // Setting in INT beats any clear landing on the same edge.
      if (r_state == ST_INT) begin
        r_irq_flag <= 1'b1;
      end else if (w_ctrl_we || w_preset_we || (w_reload && r_irq_flag)) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      TC_CTRL:   DOut = {28'd0, r_ctrl};
      TC_PRESET: DOut = r_preset;
      TC_COUNT:  DOut = r_count;
      default:   DOut = '0;
    endcase
  end

  assign IRQ         = r_irq_flag & r_ctrl[CTRL_IM];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter (default build, no prescaler).
module tb_timer_counter;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  timer_counter dut (
    .clk         (clk),
    .reset       (reset),
    .Addr        (Addr),
    .We          (We),
    .DIn         (DIn),
    .DOut        (DOut),
    .IRQ         (IRQ),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the next negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    DIn  = d;
    We   = 1'b1;
    @(negedge clk);
    We   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = DOut;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    We    = 1'b0;
    Addr  = A_CTRL;
    DIn   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_dout[%0d]: got %h expected %h", a, v, 32'd0);
      end
    end
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    @(negedge clk);
    wr(A_PRESET, 32'hDEADBEEF);
    rd(A_PRESET, v);
    n_checks++;
    if (v !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL preset_rw: got %h expected %h", v, 32'hDEADBEEF);
    end
    wr(A_COUNT, 32'h1234);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL count_ro: got %h expected %h", v, 32'd0);
    end
    wr(A_RSVD, 32'hFFFFFFFF);
    rd(A_RSVD, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL rsvd_read: got %h expected %h", v, 32'd0);
    end
    rd(A_PRESET, v);
    n_checks++;
    if (v !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rsvd_no_alias: got %h expected %h", v, 32'hDEADBEEF);
    end
    wr(A_CTRL, 32'hFFFFFFF0);
    rd(A_CTRL, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL ctrl_upper_zero: got %h expected %h", v, 32'd0);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    @(negedge clk);
    for (int e = 5; e >= 0; e--) begin
      @(negedge clk);
      rd(A_COUNT, v);
      n_checks++;
      if (v !== 32'(e)) begin
        n_fail++;
        $display("FAIL oneshot_count: got %0d expected %0d", v, e);
      end
      n_checks++;
      if (IRQ !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot_irq_early: got %b expected 0 at count %0d", IRQ, e);
      end
    end
    @(negedge clk);
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_irq_rise: got %b expected 1", IRQ);
    end
    rd(A_CTRL, v);
    n_checks++;
    if (v !== 32'h8) begin
      n_fail++;
      $display("FAIL oneshot_ctrl_en_cleared: got %h expected %h", v, 32'h8);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_irq_sticky: got %b expected 1", IRQ);
    end
    wr(A_CTRL, 32'h8);
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_irq_clear: got %b expected 0", IRQ);
    end
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL oneshot_count_hold: got %0d expected 0", v);
    end
  endtask

  task automatic test_reload();
    logic [31:0] v;
    logic        exp_irq;
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      exp_irq = (i % 6 == 0);
      n_checks++;
      if (IRQ !== exp_irq) begin
        n_fail++;
        $display("FAIL reload_irq[cyc %0d]: got %b expected %b", i, IRQ, exp_irq);
      end
    end
    rd(A_CTRL, v);
    n_checks++;
    if (v !== 32'hB) begin
      n_fail++;
      $display("FAIL reload_ctrl: got %h expected %h", v, 32'hB);
    end
    wr(A_CTRL, 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mask();
    logic [31:0] v;
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (IRQ !== 1'b0) begin
        n_fail++;
        $display("FAIL mask_irq[cyc %0d]: got %b expected 0", i, IRQ);
      end
      if (i == 7) begin
        rd(A_COUNT, v);
        n_checks++;
        if (v !== 32'd0) begin
          n_fail++;
          $display("FAIL mask_count_zero: got %0d expected 0", v);
        end
      end
    end
    rd(A_CTRL, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL mask_ctrl: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_pause_reload();
    logic [31:0] v;
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd7) begin
      n_fail++;
      $display("FAIL pause_pre: got %0d expected 7", v);
    end
    wr(A_CTRL, 32'h0);
    wr(A_PRESET, 32'd20);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd6) begin
      n_fail++;
      $display("FAIL pause_freeze: got %0d expected 6", v);
    end
    repeat (3) @(negedge clk);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd6) begin
      n_fail++;
      $display("FAIL pause_hold: got %0d expected 6", v);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL pause_state_idle: got %0d expected 0", dbg_state);
    end
    wr(A_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd20) begin
      n_fail++;
      $display("FAIL pause_reload: got %0d expected 20", v);
    end
    @(negedge clk);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd19) begin
      n_fail++;
      $display("FAIL pause_resume_dec: got %0d expected 19", v);
    end
    wr(A_CTRL, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_preset_zero();
    logic exp_irq;
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'hB);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_irq = (i % 4 == 0);
      n_checks++;
      if (IRQ !== exp_irq) begin
        n_fail++;
        $display("FAIL preset0_irq[cyc %0d]: got %b expected %b", i, IRQ, exp_irq);
      end
    end
    wr(A_CTRL, 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ctrl_in_int();
    logic [31:0] v;
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd3) begin
      n_fail++;
      $display("FAIL int_reached: got %0d expected 3", dbg_state);
    end
    wr(A_CTRL, 32'h9);
    rd(A_CTRL, v);
    n_checks++;
    if (v !== 32'h9) begin
      n_fail++;
      $display("FAIL int_ctrl_write_kept: got %h expected %h", v, 32'h9);
    end
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL int_set_wins: got %b expected 1", IRQ);
    end
    repeat (2) @(negedge clk);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd2) begin
      n_fail++;
      $display("FAIL int_restart_count: got %0d expected 2", v);
    end
    wr(A_CTRL, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    repeat (4) @(negedge clk);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd8) begin
      n_fail++;
      $display("FAIL midreset_pre: got %0d expected 8", v);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL midreset_dout[%0d]: got %h expected %h", a, v, 32'd0);
      end
    end
    n_checks++;
    if (IRQ !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_irq_state: got irq=%b state=%0d expected irq=0 state=0", IRQ, dbg_state);
    end
    repeat (3) @(negedge clk);
    rd(A_COUNT, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_stays_idle: got %0d expected 0", v);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_oneshot();
    test_reload();
    test_mask();
    test_pause_reload();
    test_preset_zero();
    test_ctrl_in_int();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped timer device on the system bridge; the source end of the interrupt path into the coprocessor's HWInt inputs.
- The CPU programs it with sw/lw through the bridge. It counts down from a preset value and raises IRQ, which is wired to one HWInt bit.
- Supports one-shot (mode 0) and auto-reload (mode 1) operation.

Parameters:
- PRESCALE, 1: number of clk cycles per count decrement. Legal range 1..65535. Honoured only when TC_PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Addr  in  2  word offset (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- We  in  1  write enable from bridge
- DIn  in  32  write data
- DOut  out  32  read data, combinational from Addr
- IRQ  out  1  interrupt request to CP0 HWInt

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Registers:
  - CTRL[0] = EN (enable).
  - CTRL[2:1] = MODE: 2'b01 is auto-reload; every other value is one-shot.
  - CTRL[3] = IM (interrupt mask, 1 = allow).
  - CTRL[31:4] read as 0.
  - PRESET is 32-bit read/write.
  - COUNT is 32-bit read-only; writes to it are ignored.
  - Addr 3 reads 0.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0, DOut reflects zeroed registers.
- Writes: when We=1 at a clk edge, CTRL<=DIn[3:0] or PRESET<=DIn. A CPU write takes priority over any FSM update to the same register in that cycle.
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT>1, COUNT<=COUNT-1 and stay. Else (COUNT is 1 or 0), COUNT<=0 and go to INT.
  - INT: irq_flag<=1.
    - One-shot: EN<=0 (unless overwritten by a CPU CTRL write in the same cycle), go to IDLE.
    - Auto-reload: go to IDLE with EN unchanged.
- Auto-reload period: PRESET=N≥1 gives an INT cycle every N+3 clks. PRESET=0 gives a period of 4.
- IRQ = irq_flag & IM.
- irq_flag behaviour:
  - One-shot: sticky; cleared on any CPU write to CTRL or PRESET.
  - Auto-reload: high for exactly the one cycle after the INT state, then cleared automatically.
  - A CPU write clearing the flag in the same cycle INT sets it: the set wins.
- Writing PRESET mid-count does not disturb COUNT; the new value takes effect at the next LOAD.
- Clearing EN mid-count freezes COUNT. Re-enabling reloads from PRESET; it does not resume.
- A reset asserted mid-count overrides everything: all state returns to reset values on that edge.
- COUNT never wraps below 0.

Optional Feature:
- TC_PRESCALE_EN defined:
  - A 16-bit prescaler counter gates each CNT decrement and the CNT→INT transition to one every PRESCALE clks.
  - The prescaler clears in LOAD and when EN=0.
  - Auto-reload period becomes N*PRESCALE+3 for N≥1.
- TC_PRESCALE_EN undefined: every CNT cycle acts; PRESCALE is ignored; no prescaler logic is present.

Decomposition:
- Shared package holds:
  - Register offset constants: TC_CTRL=0, TC_PRESET=1, TC_COUNT=2.
  - CTRL bit-field position constants: EN, MODE, IM.
  - Mode encodings: MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01.
  - FSM state encoding: IDLE, LOAD, CNT, INT.
- One natural sub-module, tc_prescaler (the optional divider producing a tick strobe), instantiated only under TC_PRESCALE_EN.

Test Plan:
- Reset: assert reset for 2 clks → DOut=0 for Addr 0..3, IRQ=0.
- One-shot:
  - Stimulus: PRESET=5, then CTRL=0x9 (EN=1, mode 0, IM=1).
  - Response: COUNT reads 5,4,3,2,1,0. IRQ rises 1 clk after INT and stays high. CTRL reads 0x8.
  - Writing CTRL=0x8 drops IRQ next clk.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Response: IRQ pulses exactly 1 clk wide, every 6 clks, for 4 consecutive periods. CTRL stays 0xB.
- Mask: same as the one-shot case but with CTRL=0x1 → IRQ stays 0, COUNT still reaches 0, CTRL reads 0x0.
- Pause/reload:
  - Stimulus: PRESET=10, EN=1; clear EN when COUNT=6 and write PRESET=20.
  - Response: COUNT holds at 6. On re-enable, COUNT reloads to 20.
- Boundaries:
  - PRESET=0 in auto-reload → IRQ pulse every 4 clks.
  - A CTRL write landing in the INT cycle of one-shot → the written EN value is kept.
  - reset asserted mid-CNT → all registers read 0 next clk.
